lfsr_prbs_check: RTL and testbench

//  Receive-side PRBS checker, the counterpart to the lfsr PRBS generator.

---
 rtl/lfsr_prbs_check.sv | 156 +++++++++++++++
 tb/tb_lfsr_prbs_check.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_check.sv
// Receive-side PRBS checker: self-synchronises to a parallel PRBS word stream,
// then free-runs a local reference and counts bit errors.
module lfsr_prbs_check #(
  parameter int                    LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
  parameter bit                    REVERSE       = 1'b0,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    UNLOCK_COUNT  = 4,
  parameter int                    ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_in_valid,
  input  logic                     clear_count,
  output logic                     locked,
  output logic                     error,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic                     lock_lost
);

  // state  | meaning
  // FILL   | loading received bits into the history register
  // HUNT   | history tracks received bits; counting consecutive clean words
  // LOCKED | history free-runs on predicted bits; bit errors are counted
  typedef enum logic [1:0] {ST_FILL, ST_HUNT, ST_LOCKED} state_e;

  localparam int NERR_W = $clog2(DATA_WIDTH + 1);
  localparam int FILL_W = $clog2(LFSR_WIDTH + DATA_WIDTH + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
  localparam int SUM_W  = ((ERR_CNT_WIDTH > NERR_W) ? ERR_CNT_WIDTH : NERR_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_CNT_WIDTH{1'b1}});

  // h[j] holds the bit j+1 positions back in time, so tap i maps to h[N-1-i].
  function automatic logic [LFSR_WIDTH-1:0] tap_mask();
    logic [LFSR_WIDTH-1:0] m;
    m = '0;
    for (int j = 0; j < LFSR_WIDTH; j++) m[j] = LFSR_POLY[LFSR_WIDTH-1-j];
    return m;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_MASK = tap_mask();

  state_e                   state_q, state_d;
  logic [LFSR_WIDTH-1:0]    h_q, h_d;
  logic [FILL_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic [GOOD_W-1:0]        good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]         bad_cnt_q, bad_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     locked_q, locked_d;
  logic                     error_q, error_d;
  logic                     lock_lost_q, lock_lost_d;

  logic [LFSR_WIDTH-1:0]    h_next;
  logic [DATA_WIDTH-1:0]    mism;
  logic [NERR_W-1:0]        nerr;
  logic                     exp_bit;
  logic                     rx_bit;
  logic [SUM_W-1:0]         sum;

  always_comb begin
    h_next  = h_q;
    mism    = '0;
    nerr    = '0;
    exp_bit = 1'b0;
    rx_bit  = 1'b0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      rx_bit  = REVERSE ? data_in[k] : data_in[DATA_WIDTH-1-k];
      exp_bit = ^(h_next & POLY_MASK);
      mism[k] = rx_bit ^ exp_bit;
      h_next  = {h_next[LFSR_WIDTH-2:0], (state_q == ST_LOCKED) ? exp_bit : rx_bit};
    end
    for (int k = 0; k < DATA_WIDTH; k++) nerr = nerr + NERR_W'(mism[k]);
  end

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_cnt_d  = fill_cnt_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    lock_lost_d = 1'b0;
    error_d     = 1'b0;
    sum         = '0;
    err_cnt_d   = clear_count ? '0 : err_cnt_q;
    if (data_in_valid) begin
      h_d = h_next;
      case (state_q)
        ST_FILL: begin
          fill_cnt_d = fill_cnt_q + FILL_W'(DATA_WIDTH);
          if (fill_cnt_d >= FILL_W'(LFSR_WIDTH)) begin
            state_d    = ST_HUNT;
            good_cnt_d = '0;
          end
        end
        ST_HUNT: begin
          // an all-zero history predicts all zeros, so it can never prove lock
          if (nerr == '0 && h_q != '0) good_cnt_d = good_cnt_q + GOOD_W'(1);
          else                         good_cnt_d = '0;
          if (good_cnt_d == GOOD_W'(LOCK_COUNT)) begin
            state_d   = ST_LOCKED;
            bad_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          sum       = SUM_W'(err_cnt_d) + SUM_W'(nerr);
          err_cnt_d = (sum > CNT_MAX) ? '1 : sum[ERR_CNT_WIDTH-1:0];
          error_d   = (nerr != '0);
          bad_cnt_d = (nerr != '0) ? bad_cnt_q + BAD_W'(1) : '0;
          if (bad_cnt_d == BAD_W'(UNLOCK_COUNT)) begin
            state_d     = ST_FILL;
            fill_cnt_d  = '0;
            lock_lost_d = 1'b1;
          end
        end
        default: begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      h_q         <= '0;
      fill_cnt_q  <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_cnt_q  <= fill_cnt_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign error_count = err_cnt_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Bench for lfsr_prbs_check: PRBS31 stream generator plus a bit-level
// reference checker model, with a 32-bit and a 4-bit error counter instance.
module tb_lfsr_prbs_check;

  localparam int N  = 31;
  localparam int DW = 8;
  localparam int LOCKN = 16;
  localparam int UNLOCKN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        valid;
  logic        clear_count;
  bit          sel;
  logic        valid_a, valid_b;

  logic        locked_a, error_a, lock_lost_a;
  logic [31:0] error_count_a;
  logic        locked_b, error_b, lock_lost_b;
  logic [3:0]  error_count_b;

  int checks = 0;
  int errors = 0;

  assign valid_a = valid && !sel;
  assign valid_b = valid && sel;

  always #5 clk = ~clk;

  lfsr_prbs_check dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(valid_a),
    .clear_count(clear_count), .locked(locked_a), .error(error_a),
    .error_count(error_count_a), .lock_lost(lock_lost_a));

  lfsr_prbs_check #(.ERR_CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(valid_b),
    .clear_count(clear_count), .locked(locked_b), .error(error_b),
    .error_count(error_count_b), .lock_lost(lock_lost_b));

  logic [30:0] poly = 31'h10000001;

  // stream generator: bit n = XOR of bit n-(N-i) over the set taps i
  bit g_hist[$];
  // reference checker, kept as a plain bit history and a few integers
  bit     m_hist[$];
  int     m_st;   // 0 fill, 1 hunt, 2 locked
  int     m_fill, m_good, m_bad, m_nerr;
  longint m_cnt;
  bit     m_err, m_lost;

  function automatic void gen_reset();
    g_hist = {};
    for (int i = 0; i < N; i++) g_hist.push_back(1'b1);
  endfunction

  function automatic logic [7:0] gen_word();
    logic [7:0] w;
    bit b;
    w = '0;
    for (int k = 0; k < DW; k++) begin
      b = 1'b0;
      for (int i = 0; i < N; i++) if (poly[i]) b ^= g_hist[g_hist.size() - (N - i)];
      w[DW-1-k] = b;
      g_hist.push_back(b);
      void'(g_hist.pop_front());
    end
    return w;
  endfunction

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < N; i++) m_hist.push_back(1'b0);
    m_st = 0; m_fill = 0; m_good = 0; m_bad = 0; m_nerr = 0;
    m_cnt = 0; m_err = 1'b0; m_lost = 1'b0;
  endfunction

  function automatic void model_step(logic [7:0] d, bit v, bit clr, longint cmax);
    bit hz, rx, e;
    int nerr;
    m_err  = 1'b0;
    m_lost = 1'b0;
    m_nerr = 0;
    if (clr) m_cnt = 0;
    if (!v) return;
    hz = 1'b0;
    foreach (m_hist[j]) hz |= m_hist[j];
    nerr = 0;
    for (int k = 0; k < DW; k++) begin
      rx = d[DW-1-k];
      e  = 1'b0;
      for (int i = 0; i < N; i++) if (poly[i]) e ^= m_hist[m_hist.size() - (N - i)];
      if (rx != e) nerr++;
      m_hist.push_back((m_st == 2) ? e : rx);
      void'(m_hist.pop_front());
    end
    m_nerr = nerr;
    if (m_st == 0) begin
      m_fill += DW;
      if (m_fill >= N) begin m_st = 1; m_good = 0; end
    end else if (m_st == 1) begin
      if (nerr == 0 && hz) m_good++; else m_good = 0;
      if (m_good == LOCKN) begin m_st = 2; m_bad = 0; end
    end else begin
      m_cnt += nerr;
      if (m_cnt > cmax) m_cnt = cmax;
      m_err = (nerr > 0);
      if (nerr > 0) m_bad++; else m_bad = 0;
      if (m_bad == UNLOCKN) begin m_st = 0; m_fill = 0; m_lost = 1'b1; end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic compare_model();
    if (!sel) begin
      chk("locked_a", 64'(locked_a), 64'(m_st == 2));
      chk("error_a", 64'(error_a), 64'(m_err));
      chk("lock_lost_a", 64'(lock_lost_a), 64'(m_lost));
      chk("error_count_a", 64'(error_count_a), 64'(m_cnt));
    end else begin
      chk("locked_b", 64'(locked_b), 64'(m_st == 2));
      chk("error_b", 64'(error_b), 64'(m_err));
      chk("lock_lost_b", 64'(lock_lost_b), 64'(m_lost));
      chk("error_count_b", 64'(error_count_b), 64'(m_cnt));
    end
  endtask

  task automatic step(input logic [7:0] d, input bit v, input bit clr);
    data_in = d; valid = v; clear_count = clr;
    @(posedge clk); #1;
    model_step(d, v, clr, sel ? 64'd15 : 64'hffff_ffff);
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b1; data_in = 8'h5a; clear_count = 1'b0;
    @(posedge clk); #1;
    model_reset();
    compare_model();
    rst_n = 1'b1;
  endtask

  int lock_at, vwords, lost_at, consec;
  bit seen_lock, seen_err;
  logic [7:0] rnd, flip;

  initial begin
    sel = 1'b0; rst_n = 1'b0; valid = 1'b0; data_in = '0; clear_count = 1'b0;
    @(posedge clk); #1;
    do_reset();
    gen_reset();

    // loopback lock and long clean run
    lock_at = -1; seen_err = 1'b0;
    for (int w = 1; w <= 1000; w++) begin
      step(gen_word(), 1'b1, 1'b0);
      if (lock_at < 0 && locked_a) lock_at = w;
      if (error_a) seen_err = 1'b1;
    end
    chk("t1_lock_word", 64'(lock_at), 64'd20);
    chk("t1_error_seen", 64'(seen_err), 64'd0);
    chk("t1_error_count", 64'(error_count_a), 64'd0);

    // single inverted bit while locked
    step(gen_word() ^ 8'h08, 1'b1, 1'b0);
    chk("t2_error_hi", 64'(error_a), 64'd1);
    step(gen_word(), 1'b1, 1'b0);
    chk("t2_error_lo", 64'(error_a), 64'd0);
    chk("t2_locked", 64'(locked_a), 64'd1);
    for (int w = 0; w < 20; w++) step(gen_word(), 1'b1, 1'b0);
    chk("t2_count", 64'(error_count_a), 64'd1);
    step(8'h00, 1'b0, 1'b1);
    chk("t2_clear_alone", 64'(error_count_a), 64'd0);

    // reset while locked
    do_reset();
    chk("rst_locked", 64'(locked_a), 64'd0);

    // random valid gaps: lock still takes 20 valid words
    lock_at = -1; vwords = 0;
    for (int c = 0; c < 600; c++) begin
      bit v;
      v = ($urandom_range(0, 99) >= 30);
      rnd = 8'($urandom);
      step(v ? gen_word() : rnd, v, 1'b0);
      if (v) vwords++;
      if (lock_at < 0 && locked_a) lock_at = vwords;
    end
    chk("t3_lock_word", 64'(lock_at), 64'd20);
    chk("t3_error_count", 64'(error_count_a), 64'd0);

    // constant streams never lock
    do_reset();
    seen_lock = 1'b0;
    for (int w = 0; w < 200; w++) begin
      step(8'h00, 1'b1, 1'b0);
      if (locked_a) seen_lock = 1'b1;
    end
    chk("t4_zero_nolock", 64'(seen_lock), 64'd0);
    seen_lock = 1'b0;
    for (int w = 0; w < 200; w++) begin
      step(8'hff, 1'b1, 1'b0);
      if (locked_a) seen_lock = 1'b1;
    end
    chk("t4_ones_nolock", 64'(seen_lock), 64'd0);

    // lose lock on random data, then relock
    do_reset();
    for (int w = 0; w < 30; w++) step(gen_word(), 1'b1, 1'b0);
    chk("t5_locked", 64'(locked_a), 64'd1);
    lost_at = -1; consec = 0;
    for (int w = 0; w < 40 && lost_at < 0; w++) begin
      rnd = 8'($urandom);
      step(rnd, 1'b1, 1'b0);
      consec = (m_nerr > 0) ? consec + 1 : 0;
      if (lock_lost_a) lost_at = consec;
    end
    chk("t5_lost_after", 64'(lost_at), 64'd4);
    chk("t5_unlocked", 64'(locked_a), 64'd0);
    step(gen_word(), 1'b1, 1'b0);
    chk("t5_lost_pulse", 64'(lock_lost_a), 64'd0);
    lock_at = -1;
    for (int w = 2; w <= 40; w++) begin
      step(gen_word(), 1'b1, 1'b0);
      if (lock_at < 0 && locked_a) lock_at = w;
    end
    chk("t5_relock_word", 64'(lock_at), 64'd20);

    // 4-bit counter saturation and clear-with-add
    sel = 1'b1;
    do_reset();
    for (int w = 0; w < 22; w++) step(gen_word(), 1'b1, 1'b0);
    chk("t6_locked", 64'(locked_b), 64'd1);
    for (int e = 0; e < 20; e++) begin
      flip = 8'h01 << (e % 8);
      step(gen_word() ^ flip, 1'b1, 1'b0);
      step(gen_word(), 1'b1, 1'b0);
    end
    chk("t6_saturated", 64'(error_count_b), 64'd15);
    chk("t6_still_locked", 64'(locked_b), 64'd1);
    step(gen_word() ^ 8'h22, 1'b1, 1'b1);
    chk("t6_clear_add", 64'(error_count_b), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
